// File: rtl/regbank_pkg.sv
// Shared defaults and helpers for the processor register bank.
package regbank_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_NUM_REGS = 4;

  function automatic int addr_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// One registered read port: storage mux, write-first bypass, and the scoreboard bit.
module reg_read_port
  import regbank_pkg::*;
#(
  parameter int  DATA_W    = DEFAULT_DATA_W,
  parameter int  NUM_REGS  = DEFAULT_NUM_REGS,
  parameter bit  ZERO_REG0 = 1'b0,
  localparam int ADDR_W    = addr_w(NUM_REGS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              written,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_vld
);

  logic [DATA_W-1:0] data_nxt_s;
  logic              vld_nxt_s;

  // Select next output: hardwired zero first, then same-cycle write, then storage
  always_comb begin
    data_nxt_s = regs[rd_addr];
    vld_nxt_s  = written[rd_addr];
    if (ZERO_REG0 && (rd_addr == '0)) begin
      data_nxt_s = '0;
      vld_nxt_s  = 1'b1;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      data_nxt_s = wr_data;
      vld_nxt_s  = 1'b1;
    end else begin
      data_nxt_s = regs[rd_addr];
      vld_nxt_s  = written[rd_addr];
    end
  end

  // Output flops; the address is re-sampled every cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_data <= data_nxt_s;
      rd_vld  <= vld_nxt_s;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// N x DATA_W register file, one write port and two registered read ports with bypass
// and a per-register written scoreboard.
module reg_file_2r1w
  import regbank_pkg::*;
#(
  parameter int  DATA_W    = DEFAULT_DATA_W,
  parameter int  NUM_REGS  = DEFAULT_NUM_REGS,
  parameter bit  ZERO_REG0 = 1'b0,
  localparam int ADDR_W    = addr_w(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_vld_a,
  output logic              rd_vld_b
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_r;
  logic [NUM_REGS-1:0]             written_r;
  logic [NUM_REGS-1:0]             wr_sel_s;

  // One-hot write decode; a hardwired-zero register 0 never gets selected
  always_comb begin
    wr_sel_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ZERO_REG0 && (i == 0)) begin
        wr_sel_s[i] = 1'b0;
      end else begin
        wr_sel_s[i] = wr_en && (wr_addr == ADDR_W'(i));
      end
    end
  end

  // Storage and scoreboard; reset takes priority over a same-cycle write
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_r    <= '0;
      written_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel_s[i]) begin
          regs_r[i]    <= wr_data;
          written_r[i] <= 1'b1;
        end
      end
    end
  end

  reg_read_port #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .ZERO_REG0 (ZERO_REG0)
  ) u_port_a (
    .clock   (clock),
    .reset   (reset),
    .regs    (regs_r),
    .written (written_r),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_a),
    .rd_data (rd_data_a),
    .rd_vld  (rd_vld_a)
  );

  reg_read_port #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .ZERO_REG0 (ZERO_REG0)
  ) u_port_b (
    .clock   (clock),
    .reset   (reset),
    .regs    (regs_r),
    .written (written_r),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_b),
    .rd_data (rd_data_b),
    .rd_vld  (rd_vld_b)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: default, hardwired-zero and 16x16 configurations.
module tb_reg_file_2r1w;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // default configuration
  logic       reset, wr_en;
  logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data, rd_data_a, rd_data_b;
  logic       rd_vld_a, rd_vld_b;

  // ZERO_REG0 = 1
  logic       z_reset, z_wr_en;
  logic [1:0] z_wr_addr, z_rd_addr_a, z_rd_addr_b;
  logic [7:0] z_wr_data, z_rd_data_a, z_rd_data_b;
  logic       z_rd_vld_a, z_rd_vld_b;

  // DATA_W = 16, NUM_REGS = 16
  logic        w_reset, w_wr_en;
  logic [3:0]  w_wr_addr, w_rd_addr_a, w_rd_addr_b;
  logic [15:0] w_wr_data, w_rd_data_a, w_rd_data_b;
  logic        w_rd_vld_a, w_rd_vld_b;

  reg_file_2r1w dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .rd_vld_a(rd_vld_a), .rd_vld_b(rd_vld_b));

  reg_file_2r1w #(.ZERO_REG0(1'b1)) dut_z (
    .clock(clock), .reset(z_reset), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .rd_addr_a(z_rd_addr_a), .rd_addr_b(z_rd_addr_b), .rd_data_a(z_rd_data_a),
    .rd_data_b(z_rd_data_b), .rd_vld_a(z_rd_vld_a), .rd_vld_b(z_rd_vld_b));

  reg_file_2r1w #(.DATA_W(16), .NUM_REGS(16)) dut_w (
    .clock(clock), .reset(w_reset), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b), .rd_data_a(w_rd_data_a),
    .rd_data_b(w_rd_data_b), .rd_vld_a(w_rd_vld_a), .rd_vld_b(w_rd_vld_b));

  typedef struct {
    logic       rst;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] ea;
    logic       eva;
    logic [7:0] eb;
    logic       evb;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle and land 1 time unit past the edge, away from it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //            rst   we    wa    wd     ra    rb    ea     eva   eb     evb
    vecs[0]  = '{1'b1, 1'b1, 2'd1, 8'hFF, 2'd1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0}; // reset beats write+bypass
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 8'h00, 1'b0, 8'h00, 1'b0}; // r1 still empty
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 2'd0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 8'hA5, 1'b1, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 8'h11, 2'd2, 2'd3, 8'hA5, 1'b1, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 8'h22, 2'd1, 2'd2, 8'h22, 1'b1, 8'hA5, 1'b1}; // bypass new value
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 8'h22, 1'b1, 8'h22, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 8'h3C, 2'd3, 2'd0, 8'h3C, 1'b1, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 8'h3C, 1'b1, 8'h3C, 1'b1}; // same address
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 8'h5A, 2'd0, 2'd1, 8'h5A, 1'b1, 8'h22, 1'b1}; // r0 writable here
    vecs[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd2, 8'h5A, 1'b1, 8'hA5, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd2, 8'h5A, 1'b1, 8'hA5, 1'b1}; // hold
    vecs[12] = '{1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0}; // mid reset
    vecs[13] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 2'd2, 8'h00, 1'b0, 8'h00, 1'b0};

    reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
    z_reset = 1'b1; z_wr_en = 1'b0; z_wr_addr = 2'd0; z_wr_data = 8'h00;
    z_rd_addr_a = 2'd0; z_rd_addr_b = 2'd0;
    w_reset = 1'b1; w_wr_en = 1'b0; w_wr_addr = 4'd0; w_wr_data = 16'h0000;
    w_rd_addr_a = 4'd0; w_rd_addr_b = 4'd0;
    step();

    for (int i = 0; i < NVEC; i++) begin
      reset = vecs[i].rst; wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      step();
      check($sformatf("vec%0d rd_data_a", i), 32'(rd_data_a), 32'(vecs[i].ea));
      check($sformatf("vec%0d rd_vld_a", i), 32'(rd_vld_a), 32'(vecs[i].eva));
      check($sformatf("vec%0d rd_data_b", i), 32'(rd_data_b), 32'(vecs[i].eb));
      check($sformatf("vec%0d rd_vld_b", i), 32'(rd_vld_b), 32'(vecs[i].evb));
    end

    // Hardwired zero: reset state, then writes to r0 dropped, bypass suppressed
    check("z reset rd_vld_a", 32'(z_rd_vld_a), 32'd0);
    z_reset = 1'b0; z_wr_en = 1'b1; z_wr_addr = 2'd1; z_wr_data = 8'h12;
    z_rd_addr_a = 2'd1; z_rd_addr_b = 2'd2;
    step();
    check("z r1 bypass data", 32'(z_rd_data_a), 32'h12);
    check("z r2 vld empty", 32'(z_rd_vld_b), 32'd0);
    z_wr_addr = 2'd0; z_wr_data = 8'h77; z_rd_addr_a = 2'd0; z_rd_addr_b = 2'd1;
    step();
    check("z r0 write-cycle data", 32'(z_rd_data_a), 32'h00);
    check("z r0 write-cycle vld", 32'(z_rd_vld_a), 32'd1);
    check("z r1 unaffected", 32'(z_rd_data_b), 32'h12);
    z_wr_en = 1'b0; z_rd_addr_a = 2'd1; z_rd_addr_b = 2'd0;
    step();
    check("z r1 stored", 32'(z_rd_data_a), 32'h12);
    check("z r0 read data", 32'(z_rd_data_b), 32'h00);
    check("z r0 read vld", 32'(z_rd_vld_b), 32'd1);

    // Wide configuration: r15 write/read, bypass on r7, reset clears r15
    w_reset = 1'b0; w_wr_en = 1'b1; w_wr_addr = 4'd15; w_wr_data = 16'hBEEF;
    w_rd_addr_a = 4'd0; w_rd_addr_b = 4'd0;
    step();
    w_wr_addr = 4'd7; w_wr_data = 16'h1234; w_rd_addr_a = 4'd15; w_rd_addr_b = 4'd7;
    step();
    check("w r15 data", 32'(w_rd_data_a), 32'hBEEF);
    check("w r15 vld", 32'(w_rd_vld_a), 32'd1);
    check("w r7 bypass", 32'(w_rd_data_b), 32'h1234);
    w_wr_en = 1'b0; w_reset = 1'b1;
    step();
    check("w reset data", 32'(w_rd_data_a), 32'h0000);
    w_reset = 1'b0; w_rd_addr_a = 4'd15; w_rd_addr_b = 4'd7;
    step();
    check("w r15 after reset", 32'(w_rd_data_a), 32'h0000);
    check("w r15 vld after reset", 32'(w_rd_vld_a), 32'd0);
    check("w r7 after reset", 32'(w_rd_data_b), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
